// File: rtl/uart_frame_sender_pkg.sv
// Shared constants and encodings for the UART frame sender and the PC-side frame parser model.
package uart_frame_sender_pkg;

  localparam logic [7:0] SYNC0 = 8'hA5;
  localparam logic [7:0] SYNC1 = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT_TX = 3'd2,
    ST_FETCH   = 3'd3,
    ST_LATCH   = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // One-hot byte selector, same style as the transmitter FSM.
  typedef enum logic [4:0] {
    SEL_HDR0    = 5'b00001,
    SEL_HDR1    = 5'b00010,
    SEL_SEQ     = 5'b00100,
    SEL_PAYLOAD = 5'b01000,
    SEL_CSUM    = 5'b10000
  } sel_e;

endpackage

// File: rtl/uart_frame_sender.sv
// Streams one bitmap frame (sync header, seq, payload from RAM, XOR checksum) to the
// byte-level UART transmitter per frame_start request.
module uart_frame_sender #(
  parameter int unsigned NUM_BYTES  = 320,
  parameter int unsigned ADDR_WIDTH = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1,
  parameter logic [7:0]  SYNC0      = uart_frame_sender_pkg::SYNC0,
  parameter logic [7:0]  SYNC1      = uart_frame_sender_pkg::SYNC1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  frame_start,
  output logic                  busy,
  output logic                  frame_done,
  output logic [7:0]            dropped_frames,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_rdata,
  output logic                  tx_data_valid,
  output logic [7:0]            tx_byte,
  input  logic                  tx_done
);

  import uart_frame_sender_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_BYTES - 1);

  state_e                r_state;
  sel_e                  r_sel;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_tx_valid;
  logic                  r_rd_en;
  logic                  r_gap;
  logic [7:0]            r_tx_byte;
  logic [7:0]            r_csum;
  logic [7:0]            r_seq;
  logic [7:0]            r_dropped;
  logic [ADDR_WIDTH-1:0] r_addr;

  // Frame sequencer; strobes default low and are raised on entry to ISSUE/FETCH/IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_sel      <= SEL_HDR0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_tx_valid <= 1'b0;
      r_rd_en    <= 1'b0;
      r_gap      <= 1'b0;
      r_tx_byte  <= 8'h00;
      r_csum     <= 8'h00;
      r_seq      <= 8'h00;
      r_dropped  <= 8'h00;
      r_addr     <= '0;
    end else begin
      r_tx_valid <= 1'b0;
      r_rd_en    <= 1'b0;
      r_done     <= 1'b0;

      if (frame_start && (r_state != ST_IDLE) && (r_dropped != 8'hFF)) begin
        r_dropped <= r_dropped + 8'd1;
      end

      case (r_state)
        ST_IDLE: begin
          if (frame_start) begin
            r_busy     <= 1'b1;
            r_csum     <= 8'h00;
            r_sel      <= SEL_HDR0;
            r_tx_byte  <= SYNC0;
            r_tx_valid <= 1'b1;
            r_gap      <= 1'b0;
            r_state    <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          r_state <= ST_WAIT_TX;
        end

        // One spare cycle after tx_done lets the transmitter settle back to idle.
        ST_WAIT_TX: begin
          if (r_gap) begin
            r_gap <= 1'b0;
            case (r_sel)
              SEL_HDR0: begin
                r_tx_byte  <= SYNC1;
                r_sel      <= SEL_HDR1;
                r_tx_valid <= 1'b1;
                r_state    <= ST_ISSUE;
              end
              SEL_HDR1: begin
                r_tx_byte  <= r_seq;
                r_csum     <= r_csum ^ r_seq;
                r_sel      <= SEL_SEQ;
                r_tx_valid <= 1'b1;
                r_state    <= ST_ISSUE;
              end
              SEL_SEQ: begin
                r_addr  <= '0;
                r_sel   <= SEL_PAYLOAD;
                r_rd_en <= 1'b1;
                r_state <= ST_FETCH;
              end
              SEL_PAYLOAD: begin
                if (r_addr == LAST_ADDR) begin
                  r_tx_byte  <= r_csum;
                  r_sel      <= SEL_CSUM;
                  r_tx_valid <= 1'b1;
                  r_state    <= ST_ISSUE;
                end else begin
                  r_addr  <= r_addr + ADDR_WIDTH'(1);
                  r_rd_en <= 1'b1;
                  r_state <= ST_FETCH;
                end
              end
              SEL_CSUM: begin
                r_state <= ST_DONE;
              end
              default: begin
                r_state <= ST_DONE;
              end
            endcase
          end else if (tx_done) begin
            r_gap <= 1'b1;
          end
        end

        ST_FETCH: begin
          r_state <= ST_LATCH;
        end

        ST_LATCH: begin
          r_tx_byte  <= mem_rdata;
          r_csum     <= r_csum ^ mem_rdata;
          r_tx_valid <= 1'b1;
          r_state    <= ST_ISSUE;
        end

        ST_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_seq   <= r_seq + 8'd1;
          r_state <= ST_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy           = r_busy;
  assign frame_done     = r_done;
  assign dropped_frames = r_dropped;
  assign mem_rd_en      = r_rd_en;
  assign mem_addr       = r_addr;
  assign tx_data_valid  = r_tx_valid;
  assign tx_byte        = r_tx_byte;

endmodule

// File: tb/tb_uart_frame_sender.sv
// Randomized bench for uart_frame_sender: transmitter and RAM models plus a frame-level reference model.
module tb_uart_frame_sender;

  localparam int unsigned NB = 4;
  localparam int unsigned AW = 2;

  typedef logic [7:0] byte_q_t[$];

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          frame_start = 1'b0;
  logic          busy;
  logic          frame_done;
  logic [7:0]    dropped_frames;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata = 8'h00;
  logic          tx_data_valid;
  logic [7:0]    tx_byte;
  logic          tx_done = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [7:0]  ram [NB];
  byte_q_t     rx_q;
  int unsigned tx_delay = 0;
  int unsigned done_cnt = 0;
  logic [7:0]  exp_seq = 8'h00;
  int unsigned exp_drop = 0;
  bit          hung = 1'b0;

  uart_frame_sender #(.NUM_BYTES(NB)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .frame_start    (frame_start),
    .busy           (busy),
    .frame_done     (frame_done),
    .dropped_frames (dropped_frames),
    .mem_rd_en      (mem_rd_en),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .tx_data_valid  (tx_data_valid),
    .tx_byte        (tx_byte),
    .tx_done        (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference frame: header, seq, payload, XOR of seq and payload.
  function automatic byte_q_t model_frame(input logic [7:0] seq);
    byte_q_t    q;
    logic [7:0] csum;
    q = {};
    q.push_back(8'hA5);
    q.push_back(8'h5A);
    q.push_back(seq);
    csum = seq;
    for (int i = 0; i < int'(NB); i++) begin
      q.push_back(ram[i]);
      csum = csum ^ ram[i];
    end
    q.push_back(csum);
    return q;
  endfunction

  // RAM read port: data appears exactly one cycle after the strobe, garbage otherwise.
  initial begin
    bit            rd_pend;
    logic [AW-1:0] rd_addr;
    rd_pend = 1'b0;
    rd_addr = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rd_pend) mem_rdata = ram[rd_addr];
      else mem_rdata = 8'($urandom);
      rd_pend = mem_rd_en;
      rd_addr = mem_addr;
    end
  end

  // Transmitter model: captures bytes, answers with tx_done after tx_delay cycles.
  initial begin
    bit          pending;
    int          cyc;
    int          last_done;
    int unsigned cnt;
    logic [7:0]  held;
    pending = 1'b0;
    cyc = 0;
    last_done = -100;
    cnt = 0;
    held = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      tx_done = 1'b0;
      if (frame_done) done_cnt++;
      if (!resetn) begin
        pending = 1'b0;
      end else if (pending) begin
        check("tx_byte_hold", tx_byte, held);
        check("no_early_valid", tx_data_valid, 0);
        if (cnt == 0) begin
          tx_done = 1'b1;
          pending = 1'b0;
          last_done = cyc;
        end else begin
          cnt--;
        end
      end else if (tx_data_valid) begin
        check("issue_gap", int'((cyc - last_done) >= 2), 1);
        rx_q.push_back(tx_byte);
        held = tx_byte;
        pending = 1'b1;
        cnt = tx_delay;
      end
    end
  end

  task automatic compare_frame(input logic [7:0] seq);
    byte_q_t exp_q;
    exp_q = model_frame(seq);
    check("frame_len", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("frame_byte%0d", i), (i < rx_q.size()) ? int'(rx_q[i]) : 32'h100, exp_q[i]);
    end
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    check("start_valid", tx_data_valid, 1);
    check("start_busy", busy, 1);
  endtask

  task automatic run_frame(input int unsigned delay, input int unsigned drops);
    bit ok;
    ok = 1'b0;
    rx_q.delete();
    done_cnt = 0;
    tx_delay = delay;
    start_frame();
    for (int d = 0; d < int'(drops); d++) begin
      @(posedge clk);
      #1;
      frame_start = 1'b1;
      @(posedge clk);
      #1;
      frame_start = 1'b0;
      if (exp_drop < 255) exp_drop++;
    end
    for (int i = 0; i < int'((delay + 12) * (NB + 4) + 50); i++) begin
      @(posedge clk);
      #1;
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
    check("frame_done_seen", ok, 1);
    if (!ok) begin
      hung = 1'b1;
      return;
    end
    check("busy_low_at_done", busy, 0);
    compare_frame(exp_seq);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("done_once", done_cnt, 1);
    check("dropped", dropped_frames, exp_drop);
    exp_seq = exp_seq + 8'd1;
  endtask

  initial begin
    bit ok;
    ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33; ram[3] = 8'h44;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_valid", tx_data_valid, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_dropped", dropped_frames, 0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Fixed RAM: seq 0 then seq 1 checksums.
    run_frame($urandom_range(3, 0), 0);
    if (!hung) check("csum_seq0", rx_q[NB + 3], 8'h44);
    if (!hung) run_frame($urandom_range(3, 0), 0);
    if (!hung) check("csum_seq1", rx_q[NB + 3], 8'h45);

    // Three requests while busy are dropped without disturbing the frame.
    if (!hung) run_frame(5, 3);

    // Slow transmitter.
    if (!hung) begin
      for (int i = 0; i < int'(NB); i++) ram[i] = 8'($urandom);
      run_frame(2000, 0);
    end

    // Asynchronous reset while payload byte 2 is in flight.
    if (!hung) begin
      rx_q.delete();
      tx_delay = 20;
      start_frame();
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
        @(posedge clk);
        #1;
        if (rx_q.size() >= 5) begin
          ok = 1'b1;
          break;
        end
      end
      check("reach_payload2", ok, 1);
      #2;
      resetn = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", frame_done, 0);
      check("mid_rst_valid", tx_data_valid, 0);
      check("mid_rst_rd_en", mem_rd_en, 0);
      check("mid_rst_tx_byte", tx_byte, 0);
      check("mid_rst_addr", mem_addr, 0);
      check("mid_rst_dropped", dropped_frames, 0);
      repeat (2) @(posedge clk);
      #3;
      resetn = 1'b1;
      exp_seq = 8'h00;
      exp_drop = 0;
      @(posedge clk);
      #1;
      run_frame($urandom_range(3, 0), 0);
    end

    // 256 random frames: seq wraps 255 -> 0, drop counter saturates.
    for (int f = 0; f < 256 && !hung; f++) begin
      for (int i = 0; i < int'(NB); i++) ram[i] = 8'($urandom);
      run_frame($urandom_range(3, 0), 1);
    end
    if (!hung) check("dropped_saturated", dropped_frames, 255);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
